// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg: geometry defaults, FSM encodings and line helpers
// shared by the direct-mapped instruction cache files.
// Ports: none (package). Also defines the ICACHE_TAG_W(index_bits,
// line_words_log) macro giving the tag width of a 32-bit address.

`ifndef ICACHE_TAG_W
`define ICACHE_TAG_W(ib, wl) (32 - (ib) - (wl) - 2)
`endif

package icache_direct_pkg;

   localparam int ICACHE_INDEX_BITS     = 6;
   localparam int ICACHE_LINE_WORDS_LOG = 2;

   localparam logic [0:0] ICACHE_IDLE = 1'b0;
   localparam logic [0:0] ICACHE_FILL = 1'b1;

   // Clears the word and byte offset bits, giving the line base.
   function automatic logic [31:0] line_base(
      input logic [31:0] addr,
      input int          wl
   );
      return addr & ~((32'd1 << (wl + 2)) - 32'd1);
   endfunction

endpackage

// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch-side lookup and memory-side refill signals
// of the instruction cache, bundled in one interface.
// Ports: pc_from_if/inst_valid/inst_to_if (fetch),
// mem_req_valid/mem_req_addr/mem_resp_valid/mem_resp_data (memory).
// slave = cache side, master = environment side.

interface icache_direct_if;

   logic [31:0] pc_from_if;
   logic        inst_valid;
   logic [31:0] inst_to_if;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   modport slave (
      input  pc_from_if,
      input  mem_resp_valid,
      input  mem_resp_data,
      output inst_valid,
      output inst_to_if,
      output mem_req_valid,
      output mem_req_addr
   );

   modport master (
      output pc_from_if,
      output mem_resp_valid,
      output mem_resp_data,
      input  inst_valid,
      input  inst_to_if,
      input  mem_req_valid,
      input  mem_req_addr
   );

endinterface

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data flop storage for the cache lines.
// Ports: clk, rst; combinational read (rd_index, rd_word -> rd_valid,
// rd_tag, rd_data); one write port (wr_index, wr_word, wr_data,
// wr_en, set_valid + wr_tag, clr_valid).

module icache_line_array
   import icache_direct_pkg::*;
#(
   parameter int INDEX_BITS     = ICACHE_INDEX_BITS,
   parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG,
   parameter int TAG_W          = `ICACHE_TAG_W(INDEX_BITS, LINE_WORDS_LOG)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [INDEX_BITS-1:0]     rd_index,
   input  logic [LINE_WORDS_LOG-1:0] rd_word,
   output logic                      rd_valid,
   output logic [TAG_W-1:0]          rd_tag,
   output logic [31:0]               rd_data,
   input  logic [INDEX_BITS-1:0]     wr_index,
   input  logic [LINE_WORDS_LOG-1:0] wr_word,
   input  logic [31:0]               wr_data,
   input  logic                      wr_en,
   input  logic                      set_valid,
   input  logic                      clr_valid,
   input  logic [TAG_W-1:0]          wr_tag
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = 1 << LINE_WORDS_LOG;

   logic [LINES-1:0]                   valid_q, valid_d;
   logic [LINES-1:0][TAG_W-1:0]        tag_q, tag_d;
   logic [LINES-1:0][WORDS-1:0][31:0]  data_q, data_d;

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index][rd_word];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (wr_en) begin
         data_d[wr_index][wr_word] = wr_data;
      end
      if (set_valid) begin
         valid_d[wr_index] = 1'b1;
         tag_d[wr_index]   = wr_tag;
      end else if (clr_valid) begin
         valid_d[wr_index] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with a
// zero-latency hit path and word-by-word line refill on a miss.
// Ports: clk, rst (async, active-high), rdy (low freezes state),
// bus (icache_direct_if.slave: fetch lookup + memory refill).
// Optional: define ICACHE_STATS_EN to add hit_count/miss_count outputs.

module icache_direct
   import icache_direct_pkg::*;
#(
   parameter int INDEX_BITS     = ICACHE_INDEX_BITS,
   parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   icache_direct_if.slave    bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int W      = LINE_WORDS_LOG;
   localparam int TAG_W  = `ICACHE_TAG_W(INDEX_BITS, LINE_WORDS_LOG);
   localparam int IDX_LO = W + 2;
   localparam int TAG_LO = W + 2 + INDEX_BITS;

   logic [0:0]            state_q, state_d;
   logic [W-1:0]          fill_cnt_q, fill_cnt_d;
   logic [31:0]           fill_base_q, fill_base_d;
   logic                  req_valid_q, req_valid_d;
   logic [31:0]           req_addr_q, req_addr_d;

   logic [W-1:0]          pc_word;
   logic [INDEX_BITS-1:0] pc_index;
   logic [TAG_W-1:0]      pc_tag;
   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_W-1:0]      fill_tag;
   logic [W-1:0]          cnt_nxt;
   logic                  fill_last;

   logic                  rd_valid;
   logic [TAG_W-1:0]      rd_tag;
   logic [31:0]           rd_data;
   logic                  hit;
   logic                  idle;

   logic [INDEX_BITS-1:0] wr_index;
   logic                  wr_en;
   logic                  set_valid;
   logic                  clr_valid;

   logic                  unused_pc;

   assign pc_word    = bus.pc_from_if[W+1:2];
   assign pc_index   = bus.pc_from_if[TAG_LO-1:IDX_LO];
   assign pc_tag     = bus.pc_from_if[31:TAG_LO];
   assign unused_pc  = ^bus.pc_from_if[1:0];

   assign fill_index = fill_base_q[TAG_LO-1:IDX_LO];
   assign fill_tag   = fill_base_q[31:TAG_LO];
   assign cnt_nxt    = fill_cnt_q + 1'b1;
   assign fill_last  = (fill_cnt_q == {W{1'b1}});

   assign idle = (state_q == ICACHE_IDLE);
   assign hit  = rd_valid && (rd_tag == pc_tag);

   assign bus.inst_valid    = idle && hit;
   assign bus.inst_to_if    = rd_data;
   assign bus.mem_req_valid = req_valid_q;
   assign bus.mem_req_addr  = req_addr_q;

   icache_line_array #(
      .INDEX_BITS     (INDEX_BITS),
      .LINE_WORDS_LOG (LINE_WORDS_LOG),
      .TAG_W          (TAG_W)
   ) u_lines (
      .clk       (clk),
      .rst       (rst),
      .rd_index  (pc_index),
      .rd_word   (pc_word),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_index  (wr_index),
      .wr_word   (fill_cnt_q),
      .wr_data   (bus.mem_resp_data),
      .wr_en     (wr_en),
      .set_valid (set_valid),
      .clr_valid (clr_valid),
      .wr_tag    (fill_tag)
   );

   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      fill_base_d = fill_base_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      wr_index    = fill_index;
      wr_en       = 1'b0;
      set_valid   = 1'b0;
      clr_valid   = 1'b0;
      if (rdy) begin
         unique case (1'b1)
            (state_q == ICACHE_IDLE): begin
               if (!hit) begin
                  // Drop the old line now so a stale tag can never
                  // hit against a half-refilled line.
                  state_d     = ICACHE_FILL;
                  fill_base_d = line_base(bus.pc_from_if, W);
                  fill_cnt_d  = '0;
                  req_valid_d = 1'b1;
                  req_addr_d  = line_base(bus.pc_from_if, W);
                  wr_index    = pc_index;
                  clr_valid   = 1'b1;
               end
            end
            (state_q == ICACHE_FILL): begin
               if (bus.mem_resp_valid) begin
                  wr_en = 1'b1;
                  if (fill_last) begin
                     set_valid   = 1'b1;
                     state_d     = ICACHE_IDLE;
                     fill_cnt_d  = '0;
                     req_valid_d = 1'b0;
                  end else begin
                     fill_cnt_d = cnt_nxt;
                     // Base is line-aligned, so OR equals add.
                     req_addr_d = fill_base_q
                                | {{(30-W){1'b0}}, cnt_nxt, 2'b00};
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ICACHE_IDLE;
         fill_cnt_q  <= '0;
         fill_base_q <= '0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         fill_base_q <= fill_base_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic        miss_evt;

   assign miss_evt   = rdy && idle && !hit;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (rdy && bus.inst_valid && (hit_cnt_q != 32'hFFFF_FFFF)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed test of icache_direct against a
// line-residency model plus hand-computed literal expectations.

module tb_icache_direct;

   logic clk;
   logic rst;
   logic rdy;

   icache_direct_if bus();

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   icache_direct dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .bus        (bus),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );
`else
   icache_direct dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );
`endif

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Backing memory contents seen by the cache.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h11;
         32'h4:   return 32'h22;
         32'h8:   return 32'h33;
         32'hC:   return 32'h44;
         default: return a ^ 32'hDEAD_0000;
      endcase
   endfunction

   // Model: which line base is resident in each of the 64 slots,
   // plus the line currently being fetched.
   bit          m_res_v [64];
   logic [31:0] m_res_base [64];
   bit          m_fill;
   logic [31:0] m_base;
   int          m_cnt;
   logic [31:0] m_hits;
   logic [31:0] m_miss;

   function automatic int slot(input logic [31:0] a);
      return int'(a[9:4]);
   endfunction

   function automatic logic [31:0] lbase(input logic [31:0] a);
      return {a[31:4], 4'b0000};
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return !m_fill && m_res_v[slot(a)]
             && (m_res_base[slot(a)] == lbase(a));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) m_res_v[i] = 1'b0;
         m_fill = 1'b0;
         m_base = '0;
         m_cnt  = 0;
         m_hits = '0;
         m_miss = '0;
      end else if (rdy) begin
         if (m_hit(bus.pc_from_if)) m_hits = m_hits + 32'd1;
         if (!m_fill) begin
            if (!m_hit(bus.pc_from_if)) begin
               m_fill = 1'b1;
               m_base = lbase(bus.pc_from_if);
               m_cnt  = 0;
               m_res_v[slot(bus.pc_from_if)] = 1'b0;
               m_miss = m_miss + 32'd1;
            end
         end else if (bus.mem_resp_valid) begin
            m_cnt++;
            if (m_cnt == 4) begin
               m_res_v[slot(m_base)]    = 1'b1;
               m_res_base[slot(m_base)] = m_base;
               m_fill = 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         check("inst_valid", {31'd0, bus.inst_valid},
               {31'd0, m_hit(bus.pc_from_if)});
         if (m_hit(bus.pc_from_if))
            check("inst_to_if", bus.inst_to_if,
                  mem_word(bus.pc_from_if));
         check("mem_req_valid", {31'd0, bus.mem_req_valid},
               {31'd0, m_fill});
         if (m_fill)
            check("mem_req_addr", bus.mem_req_addr,
                  m_base + 32'(4 * m_cnt));
`ifdef ICACHE_STATS_EN
         check("hit_count", hit_count, m_hits);
         check("miss_count", miss_count, m_miss);
`endif
      end
   end

   // Accepted refill addresses, in order.
   logic [31:0] req_log [$];

   always @(posedge clk) begin
      if (!rst && rdy && bus.mem_req_valid && bus.mem_resp_valid)
         req_log.push_back(bus.mem_req_addr);
   end

   function automatic logic [31:0] log_at(input int i);
      if (i < req_log.size()) return req_log[i];
      return 32'hFFFF_FFFF;
   endfunction

   // Memory controller: one response per two cycles while requested.
   initial begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || bus.mem_resp_valid) begin
            bus.mem_resp_valid = 1'b0;
         end else if (bus.mem_req_valid && rdy) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_word(bus.mem_req_addr);
         end
      end
   end

   task automatic set_pc(input logic [31:0] p);
      @(posedge clk);
      #1;
      bus.pc_from_if = p;
      @(negedge clk);
   endtask

   task automatic wait_valid(input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.inst_valid && n < 200);
      if (!bus.inst_valid) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=no-hit required=hit", name);
      end
   endtask

   task automatic wait_log(input string name, input int target);
      int n;
      n = 0;
      while (req_log.size() < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (req_log.size() < target) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=%0d required=%0d",
                  name, req_log.size(), target);
      end
   endtask

   task automatic check_line_log(input string name,
                                 input int base,
                                 input logic [31:0] line);
      for (int i = 0; i < 4; i++)
         check(name, log_at(base + i), line + 32'(4 * i));
   endtask

   initial begin
      int lat;
      int b;
      rst = 1'b0;
      rdy = 1'b1;
      bus.pc_from_if = 32'h0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);

      check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      check("rst_req_addr", bus.mem_req_addr, 32'd0);
      rst = 1'b0;

      // Cold miss at 0x0.
      wait_valid("cold", lat);
      check("cold_latency", 32'(lat), 32'd8);
      check("cold_data", bus.inst_to_if, 32'h11);
      check("cold_log_size", 32'(req_log.size()), 32'd4);
      check_line_log("cold_log", 0, 32'h0);

      // Hits in the same line.
      set_pc(32'h4);
      check("hit4_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("hit4_data", bus.inst_to_if, 32'h22);
      check("hit4_noreq", {31'd0, bus.mem_req_valid}, 32'd0);
      set_pc(32'h8);
      check("hit8_data", bus.inst_to_if, 32'h33);
      set_pc(32'hC);
      check("hitC_data", bus.inst_to_if, 32'h44);

      // Conflict eviction on index 0.
      b = req_log.size();
      set_pc(32'h400);
      check("evict_miss", {31'd0, bus.inst_valid}, 32'd0);
      wait_valid("evict", lat);
      check("evict_data", bus.inst_to_if, 32'hDEAD_0400);
      check_line_log("evict_log", b, 32'h400);
      set_pc(32'h0);
      check("evicted_miss", {31'd0, bus.inst_valid}, 32'd0);
      wait_valid("refill0", lat);
      check("refill0_data", bus.inst_to_if, 32'h11);

      // Redirect during fill.
      b = req_log.size();
      set_pc(32'h100);
      wait_log("redir_first", b + 1);
      set_pc(32'h200);
      wait_valid("redir", lat);
      check("redir_data", bus.inst_to_if, 32'hDEAD_0200);
      check_line_log("redir_log_old", b, 32'h100);
      check("redir_log_new", log_at(b + 4), 32'h200);
      set_pc(32'h100);
      check("redir_old_hit", {31'd0, bus.inst_valid}, 32'd1);
      check("redir_old_data", bus.inst_to_if, 32'hDEAD_0100);

      // rdy stall mid-fill.
      b = req_log.size();
      set_pc(32'h300);
      wait_log("stall_first", b + 1);
      rdy = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
         check("stall_req_addr", bus.mem_req_addr, 32'h304);
      end
      rdy = 1'b1;
      wait_valid("stall", lat);
      check("stall_data", bus.inst_to_if, 32'hDEAD_0300);
      check_line_log("stall_log", b, 32'h300);

      // Async reset mid-fill.
      b = req_log.size();
      set_pc(32'h500);
      wait_log("arst_first", b + 1);
      #2 rst = 1'b1;
      #1;
      check("arst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      check("arst_req_addr", bus.mem_req_addr, 32'd0);
`ifdef ICACHE_STATS_EN
      check("arst_hit_count", hit_count, 32'd0);
      check("arst_miss_count", miss_count, 32'd0);
`endif
      bus.pc_from_if = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_line0_miss", {31'd0, bus.inst_valid}, 32'd0);
      wait_valid("arst_refill", lat);
      check("arst_refill_data", bus.inst_to_if, 32'h11);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache that answers the fetch stage's PC lookups.
- Output is the instruction word plus a valid flag.
- On a miss it refills a whole line through a word-wide request/response port on the memory controller.
- Sits between the fetch stage (upstream requester) and the memory controller (downstream).

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines)
LINE_WORDS_LOG, 2, log2 of 32-bit words per line (4 words = 16 B)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global ready; low freezes all state
pc_from_if  in  32  fetch address, word-aligned
inst_valid  out  1  inst_to_if holds the word at pc_from_if this cycle
inst_to_if  out  32  instruction word
mem_req_valid  out  1  word read request to memory controller
mem_req_addr  out  32  word-aligned address of requested word
mem_resp_valid  in  1  one-cycle pulse: mem_resp_data valid for the outstanding request
mem_resp_data  in  32  returned word, little-endian

Behaviour:
- Address split (W = LINE_WORDS_LOG):
  - pc[1:0] ignored.
  - word = pc[W+1:2].
  - index = pc[W+1+INDEX_BITS:W+2].
  - tag = remaining upper bits.
- Storage: valid bit, tag and LINE_WORDS data words per line, all in flops.
- Hit path is combinational, zero latency:
  - inst_valid = (state==IDLE) && valid[index] && tag[index]==tag(pc_from_if).
  - inst_to_if = data[index][word]; don't-care when inst_valid=0.
- FSM states: IDLE, FILL.
- IDLE:
  - On a miss, latch the line base (pc_from_if with word and byte bits zeroed) into fill_base.
  - Set fill_cnt=0 and go to FILL.
  - The missing line's valid bit is cleared at the same edge.
- FILL:
  - mem_req_valid=1 and mem_req_addr=fill_base+4*fill_cnt, held stable until mem_resp_valid.
  - On mem_resp_valid: write data[fill_index][fill_cnt] and increment fill_cnt.
  - After the last word: write tag, set valid, drop mem_req_valid at that edge and return to IDLE.
  - A hit is visible the following cycle: miss-to-first-hit latency = LINE_WORDS responses + 1 cycle.
- inst_valid is 0 for the whole of FILL, including lookups of other lines (no hit-under-miss).
- pc_from_if changes during FILL (branch redirect from fetch): the fill still completes into the latched line, with no abort and no request cancel. After returning to IDLE the new pc is looked up normally and may miss again.
- mem_resp_valid while in IDLE is ignored.
- rdy=0: FSM, counters, arrays and the mem_req_* outputs hold. inst_valid is still computed combinationally; the fetch stage gates it with rdy.
- Reset, async:
  - All valid bits 0, state IDLE, fill_cnt 0.
  - mem_req_valid 0, mem_req_addr 0.
  - inst_valid therefore 0.
  - Reset mid-fill abandons the fill; the memory controller is also reset by the same rst.
- Wrap-around: fill_cnt is W bits wide and its terminal value is LINE_WORDS-1. Addresses near 0xFFFF_FFF0 compute a base without overflow concern, because a line never crosses its own alignment.

Optional Feature:
ICACHE_STATS_EN
- Defined: adds outputs hit_count (32) and miss_count (32), both reset to 0, saturating at 0xFFFF_FFFF.
  - hit_count increments each rdy cycle with inst_valid=1.
  - miss_count increments on each IDLE->FILL transition.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared utils package/header:
  - ICACHE_INDEX_BITS and ICACHE_LINE_WORDS_LOG defaults.
  - FSM state encodings ICACHE_IDLE and ICACHE_FILL.
  - Tag-width derivation macro.
- One natural sub-module, icache_line_array: the valid/tag/data storage.
  - Combinational read port (index, word).
  - Single write port (index, word, data, set_valid, clr_valid, tag).
- The FSM stays in icache_direct.

Test Plan:
1. Cold miss: reset, pc=0x0000_0000; memory returns 0x11,0x22,0x33,0x44 one response each per 2 cycles -> mem_req_addr steps 0x0,0x4,0x8,0xC. inst_valid=0 throughout FILL, =1 one cycle after the last response with inst_to_if=0x11.
2. Line hits: after test 1, pc=0x4,0x8,0xC on successive cycles -> inst_valid=1 each cycle with 0x22,0x33,0x44 and no mem_req_valid.
3. Conflict eviction: pc=0x400 (same index 0, different tag) -> miss, refill from 0x400..0x40C; afterwards pc=0x0 misses again.
4. Redirect during fill: miss at 0x100; after 1 response change pc to 0x200 -> fill of 0x100..0x10C completes. Then 0x200 misses; afterwards 0x100 hits.
5. rdy stall: hold rdy=0 for 5 cycles mid-fill while mem_req_valid=1 -> mem_req_addr and fill_cnt unchanged; fill resumes correctly when rdy=1.
6. Async reset mid-fill: assert rst between clock edges -> mem_req_valid drops immediately; previously valid line 0x0 misses after reset. With ICACHE_STATS_EN, both counters read 0.
